// File: rtl/cpu_pipe_pkg.sv
// Shared widths, ALU encodings and the decode-to-execute payload
// bundle for the 16-bit CPU pipeline.
package cpu_pipe_pkg;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;
    localparam int FUNC_W = 2;
    localparam int PC_W   = 12;

    typedef enum logic [FUNC_W-1:0] {
        ALU_ADD = 2'b00,
        ALU_SUB = 2'b01,
        ALU_AND = 2'b10,
        ALU_OR  = 2'b11
    } alu_func_e;

    typedef struct packed {
        logic              reg_write;
        logic              mem_write;
        logic [FUNC_W-1:0] alufunc;
        logic [DATA_W-1:0] src1;
        logic [DATA_W-1:0] src2;
        logic [ADDR_W-1:0] destadd;
        logic [PC_W-1:0]   pc;
    } de_payload_t;

endpackage

// File: rtl/execute_pipe_reg_if.sv
// Decode-side and execute-side handshake plus payload buses
// of the decode-to-execute stage.
interface execute_pipe_reg_if;
    import cpu_pipe_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic              RegWriteD;
    logic              MemWriteD;
    logic [FUNC_W-1:0] alufuncD;
    logic [DATA_W-1:0] srcdataD1;
    logic [DATA_W-1:0] srcdataD2;
    logic [ADDR_W-1:0] destaddD;
    logic [PC_W-1:0]   pcD;

    logic              out_valid;
    logic              out_ready;
    logic              RegWriteE;
    logic              MemWriteE;
    logic [FUNC_W-1:0] alufuncE;
    logic [DATA_W-1:0] srcdataE1;
    logic [DATA_W-1:0] srcdataE2;
    logic [ADDR_W-1:0] destaddE;
    logic [PC_W-1:0]   pcE;

    modport master (
        output in_valid, RegWriteD, MemWriteD, alufuncD,
        output srcdataD1, srcdataD2, destaddD, pcD, out_ready,
        input  in_ready, out_valid, RegWriteE, MemWriteE, alufuncE,
        input  srcdataE1, srcdataE2, destaddE, pcE
    );

    modport slave (
        input  in_valid, RegWriteD, MemWriteD, alufuncD,
        input  srcdataD1, srcdataD2, destaddD, pcD, out_ready,
        output in_ready, out_valid, RegWriteE, MemWriteE, alufuncE,
        output srcdataE1, srcdataE2, destaddE, pcE
    );

endinterface

// File: rtl/execute_pipe_reg_sat_counter.sv
// Saturating event counter with synchronous clear.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/execute_pipe_reg.sv
// Elastic decode-to-execute pipeline register with flush and
// saturating stall/flush/bubble performance counters.
module execute_pipe_reg
    import cpu_pipe_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                flush,
    input  logic                cnt_clr,
    execute_pipe_reg_if.slave   bus,
    output logic [CNT_W-1:0]    stall_cnt,
    output logic [CNT_W-1:0]    flush_cnt,
    output logic [CNT_W-1:0]    bubble_cnt
);

    logic        valid_q;
    logic        valid_d;
    de_payload_t pl_q;
    de_payload_t pl_d;
    de_payload_t pl_in;
    logic        advance;

    assign pl_in = '{
        reg_write: bus.RegWriteD,
        mem_write: bus.MemWriteD,
        alufunc:   bus.alufuncD,
        src1:      bus.srcdataD1,
        src2:      bus.srcdataD2,
        destadd:   bus.destaddD,
        pc:        bus.pcD
    };

    assign advance     = ~valid_q | bus.out_ready;
    assign bus.in_ready = flush | advance;

    always_comb begin
        valid_d = valid_q;
        pl_d    = pl_q;
        if (flush) begin
            valid_d        = 1'b0;
            pl_d.reg_write = 1'b0;
            pl_d.mem_write = 1'b0;
        end else if (advance) begin
            valid_d = bus.in_valid;
            if (bus.in_valid) begin
                pl_d = pl_in;
            end else begin
                pl_d.reg_write = 1'b0;
                pl_d.mem_write = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            pl_q    <= '0;
        end else begin
            valid_q <= valid_d;
            pl_q    <= pl_d;
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.RegWriteE = pl_q.reg_write;
    assign bus.MemWriteE = pl_q.mem_write;
    assign bus.alufuncE  = pl_q.alufunc;
    assign bus.srcdataE1 = pl_q.src1;
    assign bus.srcdataE2 = pl_q.src2;
    assign bus.destaddE  = pl_q.destadd;
    assign bus.pcE       = pl_q.pc;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .inc   (valid_q & ~bus.out_ready),
        .cnt   (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .inc   (flush),
        .cnt   (flush_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .inc   (~valid_q),
        .cnt   (bubble_cnt)
    );

endmodule

// File: tb/tb_execute_pipe_reg.sv
// Directed bench for execute_pipe_reg: streaming, stall, flush,
// bubbles, counter clear/saturation and reset mid-stream.
module tb_execute_pipe_reg;

    logic clk = 1'b0;
    logic reset;
    logic flush;
    logic cnt_clr;

    logic [15:0] stall_cnt, flush_cnt, bubble_cnt;
    logic [2:0]  stall_cnt2, flush_cnt2, bubble_cnt2;

    int vectors = 0;
    int errors  = 0;

    execute_pipe_reg_if bus ();
    execute_pipe_reg_if bus2 ();

    always #5 clk = ~clk;

    execute_pipe_reg #(.CNT_W(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .cnt_clr    (cnt_clr),
        .bus        (bus),
        .stall_cnt  (stall_cnt),
        .flush_cnt  (flush_cnt),
        .bubble_cnt (bubble_cnt)
    );

    execute_pipe_reg #(.CNT_W(3)) dut_sat (
        .clk        (clk),
        .reset      (reset),
        .flush      (1'b0),
        .cnt_clr    (1'b0),
        .bus        (bus2),
        .stall_cnt  (stall_cnt2),
        .flush_cnt  (flush_cnt2),
        .bubble_cnt (bubble_cnt2)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic rw, input logic mw,
                         input logic [15:0] s1, input logic [11:0] pc);
        bus.in_valid  = v;
        bus.RegWriteD = rw;
        bus.MemWriteD = mw;
        bus.alufuncD  = 2'b01;
        bus.srcdataD1 = s1;
        bus.srcdataD2 = ~s1;
        bus.destaddD  = s1[3:0];
        bus.pcD       = pc;
    endtask

    initial begin
        reset   = 1'b1;
        flush   = 1'b0;
        cnt_clr = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 16'h0, 12'h0);
        bus.out_ready  = 1'b1;
        bus2.in_valid  = 1'b0;
        bus2.RegWriteD = 1'b0;
        bus2.MemWriteD = 1'b0;
        bus2.alufuncD  = 2'b00;
        bus2.srcdataD1 = 16'h0;
        bus2.srcdataD2 = 16'h0;
        bus2.destaddD  = 4'h0;
        bus2.pcD       = 12'h0;
        bus2.out_ready = 1'b1;
        tick();
        tick();
        reset = 1'b0;

        // reset state
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready", bus.in_ready, 1);
        chk("rst_regwrite", bus.RegWriteE, 0);
        chk("rst_pcE", bus.pcE, 0);
        chk("rst_bubble", bubble_cnt, 0);

        // bubbles then counter clear
        for (int i = 0; i < 5; i++) tick();
        chk("bub_out_valid", bus.out_valid, 0);
        chk("bub_regwrite", bus.RegWriteE, 0);
        chk("bub_cnt", bubble_cnt, 5);
        chk("bub_flush_cnt", flush_cnt, 0);
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("clr_bubble", bubble_cnt, 0);
        chk("clr_stall", stall_cnt, 0);
        chk("clr_flush", flush_cnt, 0);

        // streaming at full throughput
        for (int i = 1; i <= 4; i++) begin
            drive(1'b1, 1'b0, 1'b0, 16'(i), 12'(i));
            tick();
            chk("stream_src1", bus.srcdataE1, i);
            chk("stream_valid", bus.out_valid, 1);
        end
        chk("stream_stall", stall_cnt, 0);
        chk("stream_src2", bus.srcdataE2, 32'h0000fffb);
        chk("stream_alufunc", bus.alufuncE, 1);

        // stall holds payload and blocks input
        drive(1'b1, 1'b1, 1'b0, 16'hBEEF, 12'h010);
        tick();
        chk("stall_load", bus.srcdataE1, 32'hBEEF);
        chk("stall_load_rw", bus.RegWriteE, 1);
        drive(1'b1, 1'b0, 1'b0, 16'h1234, 12'h011);
        bus.out_ready = 1'b0;
        #1;
        chk("stall_in_ready", bus.in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("stall_hold", bus.srcdataE1, 32'hBEEF);
        end
        chk("stall_cnt3", stall_cnt, 3);
        chk("stall_rw_held", bus.RegWriteE, 1);
        bus.out_ready = 1'b1;
        tick();
        chk("stall_release", bus.srcdataE1, 32'h1234);
        chk("stall_release_rw", bus.RegWriteE, 0);
        chk("stall_release_pc", bus.pcE, 32'h011);
        chk("stall_cnt_after", stall_cnt, 3);

        // flush during stall
        drive(1'b1, 1'b1, 1'b0, 16'h5555, 12'h020);
        tick();
        drive(1'b0, 1'b0, 1'b0, 16'h0, 12'h0);
        bus.out_ready = 1'b0;
        cnt_clr = 1'b1;
        tick();
        cnt_clr = 1'b0;
        chk("pre_flush_stall", stall_cnt, 0);
        chk("pre_flush_valid", bus.out_valid, 1);
        chk("pre_flush_rw", bus.RegWriteE, 1);
        drive(1'b1, 1'b1, 1'b1, 16'h7777, 12'h021);
        flush = 1'b1;
        #1;
        chk("flush_in_ready", bus.in_ready, 1);
        tick();
        flush = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 16'h0, 12'h0);
        chk("flush_valid", bus.out_valid, 0);
        chk("flush_rw", bus.RegWriteE, 0);
        chk("flush_mw", bus.MemWriteE, 0);
        chk("flush_cnt1", flush_cnt, 1);
        chk("flush_stall1", stall_cnt, 1);
        bus.out_ready = 1'b1;

        // reset mid-stream
        drive(1'b1, 1'b1, 1'b1, 16'hA5A5, 12'h0A5);
        tick();
        chk("mid_pcE", bus.pcE, 32'h0A5);
        chk("mid_valid", bus.out_valid, 1);
        chk("mid_mw", bus.MemWriteE, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 16'h0, 12'h0);
        chk("mrst_pcE", bus.pcE, 0);
        chk("mrst_src1", bus.srcdataE1, 0);
        chk("mrst_valid", bus.out_valid, 0);
        chk("mrst_rw", bus.RegWriteE, 0);
        chk("mrst_mw", bus.MemWriteE, 0);
        chk("mrst_in_ready", bus.in_ready, 1);
        chk("mrst_stall", stall_cnt, 0);
        chk("mrst_flush", flush_cnt, 0);
        chk("mrst_bubble", bubble_cnt, 0);

        // 3-bit counter saturation on a long stall
        bus2.in_valid  = 1'b1;
        bus2.srcdataD1 = 16'hC0DE;
        bus2.out_ready = 1'b0;
        tick();
        bus2.in_valid = 1'b0;
        chk("sat_load", bus2.srcdataE1, 32'hC0DE);
        chk("sat_start", stall_cnt2, 0);
        for (int i = 1; i <= 10; i++) begin
            tick();
            chk("sat_stall", stall_cnt2, (i > 7) ? 7 : i);
        end
        chk("sat_hold_valid", bus2.out_valid, 1);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, errors);
        $finish;
    end

endmodule

// File: doc/execute_pipe_reg.md
Name: execute_pipe_reg

Overview:
Parametrised decode-to-execute pipeline register for the 16-bit CPU. It replaces the fixed always-load register with an elastic stage.
- valid/ready handshake on both sides, so execute can stall decode.
- Synchronous flush for branch/exception squash.
- PC carried into execute.
- Saturating performance counters for stall, flush and bubble cycles.
- Sits between the decoder/register-file read and the ALU/memory-write stage.

Parameters:
DATA_W, 16, width of source operands srcdata1/2
ADDR_W, 4, width of destination register address
FUNC_W, 2, width of ALU function code
PC_W, 12, width of program counter
CNT_W, 16, width of each performance counter

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
flush  in  1  squash stage contents this cycle
cnt_clr  in  1  synchronous clear of all performance counters
in_valid  in  1  decode presents a valid instruction
in_ready  out  1  stage can accept this cycle
RegWriteD  in  1  register write enable from decode
MemWriteD  in  1  memory write enable from decode
alufuncD  in  FUNC_W  ALU function from decode
srcdataD1  in  DATA_W  operand 1
srcdataD2  in  DATA_W  operand 2
destaddD  in  ADDR_W  destination register
pcD  in  PC_W  instruction PC
out_valid  out  1  execute holds a valid instruction
out_ready  in  1  execute/downstream consumes this cycle
RegWriteE  out  1  registered RegWrite, 0 when not valid
MemWriteE  out  1  registered MemWrite, 0 when not valid
alufuncE  out  FUNC_W  registered ALU function
srcdataE1  out  DATA_W  registered operand 1
srcdataE2  out  DATA_W  registered operand 2
destaddE  out  ADDR_W  registered destination
pcE  out  PC_W  registered PC
stall_cnt  out  CNT_W  cycles with out_valid=1 and out_ready=0
flush_cnt  out  CNT_W  cycles with flush=1
bubble_cnt  out  CNT_W  cycles with out_valid=0

Behaviour:
- Reset (synchronous, active-high, checked at posedge clk, highest priority):
  - All registered outputs go to 0, including out_valid and all three counters.
  - in_ready = 1 from the first cycle after reset.
- in_ready is combinational: in_ready = flush | ~out_valid | out_ready. This gives full throughput, with one combinational path from out_ready.
- accept = in_valid & in_ready. Latency is 1 cycle: data accepted at edge N appears on the E outputs after edge N.
- Priority at each posedge, highest first: reset > flush > load > hold.
- flush=1:
  - out_valid <= 0 and RegWriteE/MemWriteE <= 0.
  - Data fields may hold their value; the bench must not check them while out_valid=0.
  - Any simultaneous input handshake completes and the instruction is discarded.
  - Flush overrides a pending stall.
- Load: when not flushing and (~out_valid | out_ready):
  - out_valid <= in_valid.
  - If in_valid=1, all payload fields load.
  - If in_valid=0, this is a bubble: RegWriteE/MemWriteE <= 0 and other fields hold.
- Hold (stall): when out_valid=1, out_ready=0 and flush=0, every output keeps its value. No input is accepted because in_ready=0.
- Invariant: RegWriteE=1 or MemWriteE=1 implies out_valid=1.
- Counters:
  - Each increments by 1 per qualifying cycle, sampled before the edge, using the current out_valid.
  - Each saturates at 2^CNT_W-1 and does not wrap.
  - cnt_clr=1 sets all counters to 0 and takes priority over increment.
  - Counters are independent of flush/stall priority. A cycle with flush=1, out_valid=1 and out_ready=0 counts in both stall_cnt and flush_cnt.
- Reset mid-stall or mid-flush: the state is lost and outputs return to the reset values on the next edge.

Decomposition:
- Shared package cpu_pipe_pkg:
  - Width constants DATA_W/ADDR_W/FUNC_W/PC_W with defaults 16/4/2/12.
  - ALU function encodings.
  - Packed typedef for the decode-to-execute payload {RegWrite, MemWrite, alufunc, src1, src2, destadd, pc}.
- One natural sub-module, sat_counter, parametrised on CNT_W, with inputs inc and clr, instantiated three times.

Test Plan:
- Stream: in_valid=1 for 4 cycles, out_ready=1, srcdataD1=0x0001..0x0004 -> srcdataE1 shows 0x0001..0x0004 one cycle later, out_valid stays high, stall_cnt=0.
- Stall: load 0xBEEF with RegWriteD=1, then out_ready=0 for 3 cycles while in_valid=1 with 0x1234 -> in_ready=0, srcdataE1 holds 0xBEEF, stall_cnt=3, then 0x1234 loads on the first out_ready=1 edge.
- Flush during stall: out_valid=1, out_ready=0, RegWriteE=1, then flush=1 for one cycle -> next cycle out_valid=0, RegWriteE=0, MemWriteE=0, flush_cnt=1, stall_cnt also +1.
- Bubble: in_valid=0 for 5 cycles after reset with out_ready=1 -> out_valid=0, RegWriteE=0, bubble_cnt=5, then cnt_clr=1 gives all counters=0 next cycle.
- Saturation: with CNT_W=3, hold a stall for 10 cycles -> stall_cnt reaches 7 and stays at 7.
- Reset mid-stream: assert reset while out_valid=1 and pcE=0x0A5 -> after the edge, every output including pcE and the counters is 0 and in_ready=1.
